// File: rtl/timer_sched.sv
// Shared down-counter timer granted to one of NREQ requesters at a time.
// Define TIMER_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module timer_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] dur,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]     count_q, count_d;
  logic              any_req;
  logic              hold;
  logic [PW-1:0]     win;
  logic [CW-1:0]     win_dur;

  assign any_req = |req;
  assign hold    = |(req & gnt_q);

`ifdef TIMER_SCHED_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  function automatic logic [PW:0] rr_dist(int i, logic [PW-1:0] p);
    return (PW+1)'((i - int'(p) - 1 + 2 * NREQ) % NREQ);
  endfunction

  // Round-robin: nearest requester after the last grant wins
  always_comb begin
    logic [PW:0] best;
    best = '1;
    win  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && rr_dist(i, ptr_q) < best) begin
        best = rr_dist(i, ptr_q);
        win  = PW'(i);
      end
    end
  end

  // Pointer follows every grant, abandoned ones included
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && any_req) ptr_d = win;
  end

  // Pointer register; reset makes requester 0 first in line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= PW'(NREQ - 1);
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest requesting index wins
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = PW'(i);
    end
  end
`endif

  // Select the winner's duration field
  always_comb begin
    win_dur = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) win_dur = dur[i*CW +: CW];
    end
  end

  // State, grant and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = (win_dur == '0) ? DONE : RUN;
      end
      RUN: begin
        if (!hold)                state_d = IDLE;
        else if (count_q <= CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and counter datapath; counter only loads or counts down
  always_comb begin
    gnt_d   = gnt_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        count_d = '0;
        if (any_req) begin
          gnt_d   = NREQ'(1) << win;
          count_d = win_dur;
        end
      end
      RUN: begin
        if (!hold) begin
          gnt_d   = '0;
          count_d = '0;
        end else if (count_q != '0) begin
          count_d = count_q - CW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // Outputs: done pulses to the holder of the grant in DONE
  always_comb begin
    gnt   = gnt_q;
    done  = (state_q == DONE) ? gnt_q : '0;
    busy  = |gnt_q;
    count = count_q;
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed scoreboard bench for timer_sched (NREQ=4, CW=8).
// Expected grant order follows TIMER_SCHED_RR_EN when defined.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] dur;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  logic [3:0] order [4];

  timer_sched #(.NREQ(4), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .dur   (dur),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] g, input logic [3:0] d,
                      input logic [7:0] c);
    exp_t e;
    e.g = g;
    e.d = d;
    e.b = |g;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".gnt"},   32'(gnt),   32'(e.g));
      chk({tag, ".done"},  32'(done),  32'(e.d));
      chk({tag, ".busy"},  32'(busy),  32'(e.b));
      chk({tag, ".count"}, 32'(count), 32'(e.c));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"},   32'(gnt),   32'h0);
    chk({tag, ".done"},  32'(done),  32'h0);
    chk({tag, ".busy"},  32'(busy),  32'h0);
    chk({tag, ".count"}, 32'(count), 32'h0);
  endtask

  initial begin
`ifdef TIMER_SCHED_RR_EN
    order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`else
    order = '{default: 4'b0001};
`endif
    reset = 1'b1;
    req   = '0;
    dur   = '0;
    #3;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // single requester, dur=3, first edge after reset grants
    req = 4'b0001;
    dur[7:0] = 8'd3;
    push(4'b0001, 4'b0000, 8'd3);
    push(4'b0001, 4'b0000, 8'd2);
    push(4'b0001, 4'b0000, 8'd1);
    push(4'b0001, 4'b0001, 8'd0);
    push(4'b0000, 4'b0000, 8'd0);
    for (int k = 0; k < 5; k++) tick("basic");
    req = '0;
    push(4'b0000, 4'b0000, 8'd0);
    tick("idle");

    // zero duration: gnt and done in the same single cycle
    req = 4'b0100;
    dur[23:16] = 8'd0;
    push(4'b0100, 4'b0100, 8'd0);
    tick("dur0");
    req = '0;
    push(4'b0000, 4'b0000, 8'd0);
    tick("dur0_end");

    // arbitration order from a fresh reset, req held continuously
    reset = 1'b1;
    #2;
    chk_zero("reset2");
    reset = 1'b0;
    req = 4'b1011;
    dur = {8'd1, 8'd1, 8'd1, 8'd1};
    for (int n = 0; n < 4; n++) begin
      push(order[n], 4'b0000, 8'd1);
      push(order[n], order[n], 8'd0);
      push(4'b0000, 4'b0000, 8'd0);
    end
    for (int k = 0; k < 12; k++) tick("arb");
    req = '0;

    // abandoned request at count=6
    req = 4'b0010;
    dur[15:8] = 8'd10;
    for (int k = 0; k < 5; k++) push(4'b0010, 4'b0000, 8'(10 - k));
    for (int k = 0; k < 5; k++) tick("abandon_run");
    req = '0;
    push(4'b0000, 4'b0000, 8'd0);
    push(4'b0000, 4'b0000, 8'd0);
    tick("abandon");
    tick("abandon_idle");

    // duration change after grant does not disturb the count
    req = 4'b0001;
    dur[7:0] = 8'd4;
    push(4'b0001, 4'b0000, 8'd4);
    tick("durchg_load");
    dur[7:0] = 8'd9;
    push(4'b0001, 4'b0000, 8'd3);
    push(4'b0001, 4'b0000, 8'd2);
    push(4'b0001, 4'b0000, 8'd1);
    push(4'b0001, 4'b0001, 8'd0);
    for (int k = 0; k < 4; k++) tick("durchg");
    req = '0;
    push(4'b0000, 4'b0000, 8'd0);
    tick("durchg_end");

    // reset mid-RUN, then requester 3 at first edge after release
    req = 4'b0001;
    dur[7:0] = 8'd8;
    for (int k = 0; k < 4; k++) push(4'b0001, 4'b0000, 8'(8 - k));
    for (int k = 0; k < 4; k++) tick("pre_rst");
    reset = 1'b1;
    req = 4'b1000;
    dur[31:24] = 8'd2;
    #2;
    chk_zero("rst_run");
    reset = 1'b0;
    push(4'b1000, 4'b0000, 8'd2);
    push(4'b1000, 4'b0000, 8'd1);
    push(4'b1000, 4'b1000, 8'd0);
    for (int k = 0; k < 3; k++) tick("post_rst");
    req = '0;
    push(4'b0000, 4'b0000, 8'd0);
    tick("post_rst_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
